// File: rtl/sync_fifo_flags.sv
// Single-clock show-ahead FIFO with an exact fill count, threshold flags and sticky error flags.
// Ports: clk, rst_n, wdata/winc, rinc, flag_clr -> rdata, wfull, rempty, almost_full/empty, count, overflow/underflow.
module sync_fifo_flags #(
    parameter int unsigned DSIZE     = 8,
    parameter int unsigned ASIZE     = 4,
    parameter int unsigned AF_THRESH = 12,
    parameter int unsigned AE_THRESH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    input  logic             rinc,
    input  logic             flag_clr,
    output logic [DSIZE-1:0] rdata,
    output logic             wfull,
    output logic             rempty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [ASIZE:0]   count,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned    DEPTH   = 1 << ASIZE;
    localparam logic [ASIZE:0] DEPTH_C = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0] AF_C    = (ASIZE+1)'(AF_THRESH);
    localparam logic [ASIZE:0] AE_C    = (ASIZE+1)'(AE_THRESH);
    localparam logic           AF_RST  = (AF_THRESH == 0);

    logic [DSIZE-1:0] mem [DEPTH];

    logic [ASIZE-1:0] waddr_q, waddr_d;
    logic [ASIZE-1:0] raddr_q, raddr_d;
    logic [ASIZE:0]   count_q, count_d;
    logic             wfull_q, wfull_d;
    logic             rempty_q, rempty_d;
    logic             af_q, af_d;
    logic             ae_q, ae_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic do_wr;
    logic do_rd;

    // A write while full is allowed when a read frees the head slot
    // in the same cycle.
    assign do_wr = winc & (~wfull_q | rinc);
    assign do_rd = rinc & ~rempty_q;

    always_comb begin
        waddr_d = waddr_q;
        raddr_d = raddr_q;
        count_d = count_q;
        if (do_wr) waddr_d = waddr_q + 1'b1;
        if (do_rd) raddr_d = raddr_q + 1'b1;
        if (do_wr & ~do_rd) count_d = count_q + 1'b1;
        if (do_rd & ~do_wr) count_d = count_q - 1'b1;
    end

    // Flags are computed from the next count so they change in the
    // same cycle as count itself.
    always_comb begin
        wfull_d  = (count_d == DEPTH_C);
        rempty_d = (count_d == '0);
        af_d     = (count_d >= AF_C);
        ae_d     = (count_d <= AE_C);
        // Set takes priority over a simultaneous clear.
        ovf_d    = (ovf_q & ~flag_clr) | (winc & ~do_wr);
        unf_d    = (unf_q & ~flag_clr) | (rinc & rempty_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waddr_q  <= '0;
            raddr_q  <= '0;
            count_q  <= '0;
            wfull_q  <= 1'b0;
            rempty_q <= 1'b1;
            af_q     <= AF_RST;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            waddr_q  <= waddr_d;
            raddr_q  <= raddr_d;
            count_q  <= count_d;
            wfull_q  <= wfull_d;
            rempty_q <= rempty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (do_wr) mem[waddr_q] <= wdata;
    end

    assign rdata        = mem[raddr_q];
    assign wfull        = wfull_q;
    assign rempty       = rempty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed testbench for sync_fifo_flags with DEPTH=4, AF_THRESH=3, AE_THRESH=1.
// Each scenario task drives stimulus and checks outputs against hand-computed values.
module tb_sync_fifo_flags;

    logic       clk;
    logic       rst_n;
    logic [7:0] wdata;
    logic       winc;
    logic       rinc;
    logic       flag_clr;
    logic [7:0] rdata;
    logic       wfull;
    logic       rempty;
    logic       almost_full;
    logic       almost_empty;
    logic [2:0] count;
    logic       overflow;
    logic       underflow;

    int checks   = 0;
    int failures = 0;

    // {wfull, rempty, almost_full, almost_empty, overflow, underflow}
    logic [5:0] fl;
    assign fl = {wfull, rempty, almost_full, almost_empty, overflow, underflow};

    sync_fifo_flags #(
        .DSIZE(8), .ASIZE(2), .AF_THRESH(3), .AE_THRESH(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wdata(wdata), .winc(winc),
        .rinc(rinc), .flag_clr(flag_clr), .rdata(rdata),
        .wfull(wfull), .rempty(rempty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        winc = 1'b0;
        rinc = 1'b0;
        flag_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        wdata = 8'h00;
        step();
        step();
        checks++;
        if (count !== 3'd0) begin
            failures++;
            $display("FAIL reset_count got=%0d exp=0", count);
        end
        checks++;
        if (fl !== 6'b010100) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=010100", fl);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_fill_overflow();
        logic [5:0] ef;
        for (int i = 1; i <= 4; i++) begin
            winc = 1'b1;
            wdata = 8'hA0 + 8'(i);
            step();
            ef = {(i == 4), 1'b0, (i >= 3), (i <= 1), 2'b00};
            checks++;
            if (count !== 3'(i)) begin
                failures++;
                $display("FAIL fill_count got=%0d exp=%0d", count, i);
            end
            checks++;
            if (fl !== ef) begin
                failures++;
                $display("FAIL fill_flags i=%0d got=%b exp=%b", i, fl, ef);
            end
        end
        wdata = 8'hA5;
        step();
        winc = 1'b0;
        checks++;
        if (count !== 3'd4 || fl !== 6'b101010) begin
            failures++;
            $display("FAIL overflow got cnt=%0d fl=%b exp cnt=4 fl=101010",
                     count, fl);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rdata !== 8'hA1 + 8'(k)) begin
                failures++;
                $display("FAIL fill_read k=%0d got=%h exp=%h",
                         k, rdata, 8'hA1 + 8'(k));
            end
            rinc = 1'b1;
            step();
            rinc = 1'b0;
            checks++;
            if (count !== 3'(3 - k)) begin
                failures++;
                $display("FAIL drain_count got=%0d exp=%0d", count, 3 - k);
            end
        end
        checks++;
        if (fl !== 6'b010110) begin
            failures++;
            $display("FAIL drained_flags got=%b exp=010110", fl);
        end
        flag_clr = 1'b1;
        step();
        flag_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear got=%b exp=0", overflow);
        end
    endtask

    task automatic test_underflow_clear();
        rinc = 1'b1;
        step();
        rinc = 1'b0;
        checks++;
        if (count !== 3'd0 || fl !== 6'b010101) begin
            failures++;
            $display("FAIL underflow got cnt=%0d fl=%b exp cnt=0 fl=010101",
                     count, fl);
        end
        flag_clr = 1'b1;
        step();
        checks++;
        if (underflow !== 1'b0) begin
            failures++;
            $display("FAIL unf_clear got=%b exp=0", underflow);
        end
        rinc = 1'b1;
        step();
        rinc = 1'b0;
        checks++;
        if (underflow !== 1'b1) begin
            failures++;
            $display("FAIL unf_set_wins got=%b exp=1", underflow);
        end
        step();
        flag_clr = 1'b0;
        checks++;
        if (underflow !== 1'b0) begin
            failures++;
            $display("FAIL unf_clear2 got=%b exp=0", underflow);
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] exp_q [4];
        for (int i = 1; i <= 4; i++) begin
            winc = 1'b1;
            wdata = 8'hA0 + 8'(i);
            step();
        end
        wdata = 8'hB0;
        rinc = 1'b1;
        step();
        idle();
        checks++;
        if (count !== 3'd4 || rdata !== 8'hA2) begin
            failures++;
            $display("FAIL rw_full got cnt=%0d rd=%h exp cnt=4 rd=a2",
                     count, rdata);
        end
        checks++;
        if (fl !== 6'b101000) begin
            failures++;
            $display("FAIL rw_full_flags got=%b exp=101000", fl);
        end
        exp_q = '{8'hA2, 8'hA3, 8'hA4, 8'hB0};
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rdata !== exp_q[k]) begin
                failures++;
                $display("FAIL rw_full_read k=%0d got=%h exp=%h",
                         k, rdata, exp_q[k]);
            end
            rinc = 1'b1;
            step();
            rinc = 1'b0;
        end
        winc = 1'b1;
        rinc = 1'b1;
        wdata = 8'hC3;
        step();
        idle();
        checks++;
        if (count !== 3'd1 || fl !== 6'b000101) begin
            failures++;
            $display("FAIL rw_empty got cnt=%0d fl=%b exp cnt=1 fl=000101",
                     count, fl);
        end
        checks++;
        if (rdata !== 8'hC3) begin
            failures++;
            $display("FAIL rw_empty_data got=%h exp=c3", rdata);
        end
        rinc = 1'b1;
        flag_clr = 1'b1;
        step();
        idle();
        checks++;
        if (count !== 3'd0 || underflow !== 1'b0) begin
            failures++;
            $display("FAIL rw_empty_drain got cnt=%0d unf=%b exp 0/0",
                     count, underflow);
        end
    endtask

    task automatic test_wrap();
        // 1 = write next value, 0 = read; LSB first
        logic [19:0] ops;
        logic [7:0]  q [$];
        logic [7:0]  nxt;
        ops = 20'b00_1_00_11_00_11_00_11_00_111;
        nxt = 8'h00;
        for (int i = 0; i < 20; i++) begin
            if (ops[i]) begin
                winc = 1'b1;
                wdata = nxt;
                q.push_back(nxt);
                nxt++;
            end else begin
                checks++;
                if (q.size() == 0 || rdata !== q[0]) begin
                    failures++;
                    $display("FAIL wrap_data i=%0d got=%h", i, rdata);
                end
                if (q.size() != 0) void'(q.pop_front());
                rinc = 1'b1;
            end
            step();
            idle();
            checks++;
            if (count !== 3'(q.size())) begin
                failures++;
                $display("FAIL wrap_count i=%0d got=%0d exp=%0d",
                         i, count, q.size());
            end
        end
        checks++;
        if (nxt !== 8'h0A || overflow !== 1'b0 || underflow !== 1'b0) begin
            failures++;
            $display("FAIL wrap_end got n=%h ovf=%b unf=%b exp 0a/0/0",
                     nxt, overflow, underflow);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            winc = 1'b1;
            wdata = 8'h70 + 8'(i);
            step();
        end
        winc = 1'b0;
        checks++;
        if (count !== 3'd3) begin
            failures++;
            $display("FAIL mid_precount got=%0d exp=3", count);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (count !== 3'd0 || fl !== 6'b010100) begin
            failures++;
            $display("FAIL mid_reset got cnt=%0d fl=%b exp cnt=0 fl=010100",
                     count, fl);
        end
        step();
        rst_n = 1'b1;
        step();
        winc = 1'b1;
        wdata = 8'h5A;
        step();
        winc = 1'b0;
        checks++;
        if (rdata !== 8'h5A || count !== 3'd1) begin
            failures++;
            $display("FAIL mid_write got rd=%h cnt=%0d exp rd=5a cnt=1",
                     rdata, count);
        end
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_underflow_clear();
        test_simultaneous();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
